hilo_muldiv_ctrl: RTL and testbench

HILO_MULDIV_CTRL -- requirements
Module: hilo_muldiv_ctrl

---
 rtl/muldiv_pkg.sv | 30 +++
 rtl/muldiv_step.sv | 53 +++++
 rtl/hilo_muldiv_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_hilo_muldiv_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings, FSM state type and iteration constant for the HI/LO multiply/divide unit.
// Divider support is compiled in only when HILO_MULDIV_DIV_EN is defined.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10
  } state_t;

  localparam int unsigned ITER_COUNT = 32;
  localparam int unsigned COUNT_W    = 6;

  // MULT and DIV (Op[0] clear) treat operands as two's complement
  function automatic logic op_is_signed(input op_t op);
    return ~op[0];
  endfunction

  function automatic logic op_is_div(input op_t op);
    return op[1];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: shift-add multiply or restoring shift-subtract divide.
// The divide path exists only when HILO_MULDIV_DIV_EN is defined.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] hi_next,
  output logic [WIDTH-1:0] lo_next
);

  logic [WIDTH:0] add_sum;

  // Multiply: lo holds the remaining multiplier bits, product shifts in from the top
  always_comb begin
    add_sum = lo[0] ? ({1'b0, hi} + {1'b0, operand}) : {1'b0, hi};
  end

`ifdef HILO_MULDIV_DIV_EN
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Divide: hi is the partial remainder, lo shifts dividend out and quotient in
  always_comb begin
    shifted = {hi, lo[WIDTH-1]};
    diff    = shifted - {1'b0, operand};
    hi_next = add_sum[WIDTH:1];
    lo_next = {add_sum[0], lo[WIDTH-1:1]};
    if (is_div) begin
      if (!diff[WIDTH]) begin
        hi_next = diff[WIDTH-1:0];
        lo_next = {lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_next = shifted[WIDTH-1:0];
        lo_next = {lo[WIDTH-2:0], 1'b0};
      end
    end
  end
`else
  logic unused_is_div;
  assign unused_is_div = is_div;

  always_comb begin
    hi_next = add_sum[WIDTH:1];
    lo_next = {add_sum[0], lo[WIDTH-1:1]};
  end
`endif

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO multiply/divide controller: iterative FSM, pipeline stall and mthi/mtlo handling.
// Define HILO_MULDIV_DIV_EN to include DIV/DIVU; otherwise divide requests are ignored.
module hilo_muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  input  logic             ReadHILO,
  input  logic             HIWrite,
  input  logic             LOWrite,
  input  logic [WIDTH-1:0] WriteValue,
  output logic             Busy,
  output logic             Stall,
  output logic             Done,
  output logic [WIDTH-1:0] HIOut,
  output logic [WIDTH-1:0] LOOut
);

  localparam int unsigned        DWIDTH     = 2 * WIDTH;
  localparam logic [COUNT_W-1:0] LAST_COUNT = COUNT_W'(ITER_COUNT - 1);

  state_t             state;
  logic [COUNT_W-1:0] count;
  logic [WIDTH-1:0]   hi_reg;
  logic [WIDTH-1:0]   lo_reg;
  logic [WIDTH-1:0]   part_hi;
  logic [WIDTH-1:0]   part_lo;
  logic [WIDTH-1:0]   operand;
  logic               neg_a;
  logic               neg_b;
  logic               busy;
  logic               done;

  logic               start_ok;
  logic               signed_op;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [DWIDTH-1:0]  prod;
  logic [DWIDTH-1:0]  prod_fix;
  logic [WIDTH-1:0]   step_hi;
  logic [WIDTH-1:0]   step_lo;
  logic               step_is_div;

`ifdef HILO_MULDIV_DIV_EN
  logic               is_div;
  logic               div_zero;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  assign step_is_div = is_div;
`else
  assign step_is_div = 1'b0;
`endif

  // Operand conditioning: magnitudes plus sign flags for the signed ops
  always_comb begin
    signed_op = op_is_signed(op_t'(Op));
    a_neg     = signed_op & OperandA[WIDTH-1];
    b_neg     = signed_op & OperandB[WIDTH-1];
    mag_a     = a_neg ? -OperandA : OperandA;
    mag_b     = b_neg ? -OperandB : OperandB;
`ifdef HILO_MULDIV_DIV_EN
    start_ok  = Start;
    div_zero  = op_is_div(op_t'(Op)) & (OperandB == '0);
`else
    start_ok  = Start & ~op_is_div(op_t'(Op));
`endif
  end

  // Sign correction applied in FIX
  always_comb begin
    prod     = {part_hi, part_lo};
    prod_fix = (neg_a ^ neg_b) ? -prod : prod;
`ifdef HILO_MULDIV_DIV_EN
    quo_fix  = (neg_a ^ neg_b) ? -part_lo : part_lo;
    rem_fix  = neg_a ? -part_hi : part_hi;
`endif
  end

  muldiv_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .is_div  (step_is_div),
    .hi      (part_hi),
    .lo      (part_lo),
    .operand (operand),
    .hi_next (step_hi),
    .lo_next (step_lo)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= ST_IDLE;
      count   <= '0;
      hi_reg  <= '0;
      lo_reg  <= '0;
      part_hi <= '0;
      part_lo <= '0;
      operand <= '0;
      neg_a   <= 1'b0;
      neg_b   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef HILO_MULDIV_DIV_EN
      is_div  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start_ok) begin
            // Start takes priority; any same-cycle mthi/mtlo is dropped
            count   <= '0;
            busy    <= 1'b1;
            part_hi <= '0;
            part_lo <= mag_a;
            operand <= mag_b;
            neg_a   <= a_neg;
            neg_b   <= b_neg;
            state   <= ST_CALC;
`ifdef HILO_MULDIV_DIV_EN
            is_div  <= op_is_div(op_t'(Op));
            if (div_zero) begin
              part_hi <= OperandA;
              part_lo <= '1;
              neg_a   <= 1'b0;
              neg_b   <= 1'b0;
              state   <= ST_FIX;
            end
`endif
          end else begin
            if (HIWrite) hi_reg <= WriteValue;
            if (LOWrite) lo_reg <= WriteValue;
          end
        end
        ST_CALC: begin
          part_hi <= step_hi;
          part_lo <= step_lo;
          count   <= count + COUNT_W'(1);
          if (count == LAST_COUNT) state <= ST_FIX;
        end
        ST_FIX: begin
`ifdef HILO_MULDIV_DIV_EN
          if (is_div) begin
            hi_reg <= rem_fix;
            lo_reg <= quo_fix;
          end else begin
            hi_reg <= prod_fix[DWIDTH-1:WIDTH];
            lo_reg <= prod_fix[WIDTH-1:0];
          end
`else
          hi_reg <= prod_fix[DWIDTH-1:WIDTH];
          lo_reg <= prod_fix[WIDTH-1:0];
`endif
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign Busy  = busy;
  assign Done  = done;
  assign HIOut = hi_reg;
  assign LOOut = lo_reg;
  assign Stall = busy & (ReadHILO | Start | HIWrite | LOWrite);

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed self-checking bench for hilo_muldiv_ctrl; divide cases follow HILO_MULDIV_DIV_EN.
module tb_hilo_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] opa = '0;
  logic [31:0] opb = '0;
  logic        read_hilo = 1'b0;
  logic        hi_write = 1'b0;
  logic        lo_write = 1'b0;
  logic [31:0] write_value = '0;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hilo_muldiv_ctrl #(.WIDTH(32)) dut (
    .Clk        (clk),
    .Reset      (reset),
    .Start      (start),
    .Op         (op),
    .OperandA   (opa),
    .OperandB   (opb),
    .ReadHILO   (read_hilo),
    .HIWrite    (hi_write),
    .LOWrite    (lo_write),
    .WriteValue (write_value),
    .Busy       (busy),
    .Stall      (stall),
    .Done       (done),
    .HIOut      (hi_out),
    .LOOut      (lo_out)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one op at a negedge, wait for Done, check latency, hold-during-CALC and results
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input int exp_lat);
    logic [31:0] old_hi;
    logic [31:0] old_lo;
    int n;
    old_hi = hi_out;
    old_lo = lo_out;
    op = o; opa = a; opb = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    chk({tag, "_busy"}, 64'(busy), 64'(1));
    while (done !== 1'b1 && n < 60) begin
      if (n == 10) begin
        chk({tag, "_hold_hi"}, 64'(hi_out), 64'(old_hi));
        chk({tag, "_hold_lo"}, 64'(lo_out), 64'(old_lo));
      end
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'(exp_lat));
    chk({tag, "_hi"}, 64'(hi_out), 64'(exp_hi));
    chk({tag, "_lo"}, 64'(lo_out), 64'(exp_lo));
    @(negedge clk);
    chk({tag, "_done_pulse"}, 64'({done, busy}), 64'(0));
  endtask

  initial begin
    int n;
    int done_cnt;
    int busy_cnt;

    // Reset state
    #12;
    chk("rst_outs", 64'({busy, stall, done}), 64'(0));
    chk("rst_hi", 64'(hi_out), 64'(0));
    chk("rst_lo", 64'(lo_out), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // mthi/mtlo together, then separately
    hi_write = 1'b1; lo_write = 1'b1; write_value = 32'hA5A5_5A5A;
    @(negedge clk);
    hi_write = 1'b0; lo_write = 1'b0;
    chk("mtboth_hi", 64'(hi_out), 64'h0000_0000_A5A5_5A5A);
    chk("mtboth_lo", 64'(lo_out), 64'h0000_0000_A5A5_5A5A);
    hi_write = 1'b1; write_value = 32'h1111_1111;
    @(negedge clk);
    hi_write = 1'b0; lo_write = 1'b1; write_value = 32'h2222_2222;
    @(negedge clk);
    lo_write = 1'b0;
    chk("mthi_hi", 64'(hi_out), 64'h0000_0000_1111_1111);
    chk("mtlo_lo", 64'(lo_out), 64'h0000_0000_2222_2222);

    // Stall is zero while idle even with ReadHILO
    read_hilo = 1'b1;
    #1 chk("idle_stall", 64'(stall), 64'(0));
    read_hilo = 1'b0;

    run_op("multu_max2", 2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, 34);
    run_op("mult_m3x7", 2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 34);

    // Reset at t0+10 aborts, clears HI/LO, no Done afterwards
    op = 2'b01; opa = 32'hFFFF_FFFF; opb = 32'hFFFF_FFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_hi", 64'(hi_out), 64'(0));
    chk("abort_lo", 64'(lo_out), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
    end
    chk("abort_no_done", 64'(done_cnt), 64'(0));
    hi_write = 1'b1; write_value = 32'h0000_1234;
    @(negedge clk);
    hi_write = 1'b0;
    chk("post_abort_mthi", 64'(hi_out), 64'h0000_0000_0000_1234);

    run_op("mult_m4xm5", 2'b00, 32'hFFFF_FFFC, 32'hFFFF_FFFB, 32'h0000_0000, 32'h0000_0014, 34);
    run_op("multu_2p31sq", 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 34);
    run_op("mult_minxm1", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 34);

    // Second Start plus ReadHILO/mthi at t0+5: stall, ignored, first result intact
    op = 2'b01; opa = 32'h0000_0003; opb = 32'h0000_0004; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #1 chk("busy_nostall", 64'(stall), 64'(0));
    start = 1'b1; read_hilo = 1'b1; hi_write = 1'b1;
    opa = 32'h0000_0100; opb = 32'h0000_0100; write_value = 32'hBAD0_BAD0;
    #1 chk("busy_stall", 64'(stall), 64'(1));
    @(negedge clk);
    start = 1'b0; hi_write = 1'b0;
    #1 chk("busy_stall_read", 64'(stall), 64'(1));
    read_hilo = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("stall_op_done", 64'(done), 64'(1));
    chk("stall_op_hi", 64'(hi_out), 64'(0));
    chk("stall_op_lo", 64'(lo_out), 64'h0000_0000_0000_000C);
    done_cnt = 0;
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
      if (busy === 1'b1) busy_cnt++;
    end
    chk("second_ignored_busy", 64'(busy_cnt), 64'(0));
    chk("second_ignored_done", 64'(done_cnt), 64'(0));
    chk("second_ignored_lo", 64'(lo_out), 64'h0000_0000_0000_000C);

    // Start with mthi/mtlo in IDLE: the writes are dropped
    op = 2'b01; opa = 32'h0000_0005; opb = 32'h0000_0006; start = 1'b1;
    hi_write = 1'b1; lo_write = 1'b1; write_value = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0; hi_write = 1'b0; lo_write = 1'b0;
    chk("start_wins_hi", 64'(hi_out), 64'(0));
    chk("start_wins_lo", 64'(lo_out), 64'h0000_0000_0000_000C);
    n = 1;
    while (done !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("start_wins_lat", 64'(n), 64'(34));
    chk("start_wins_res", 64'(lo_out), 64'h0000_0000_0000_001E);
    @(negedge clk);

`ifdef HILO_MULDIV_DIV_EN
    run_op("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34);
    run_op("divu_5_0", 2'b11, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, 2);
    run_op("div_100_m7", 2'b10, 32'h0000_0064, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2, 34);
    run_op("divu_max_16", 2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, 34);
    run_op("div_m8_0", 2'b10, 32'hFFFF_FFF8, 32'h0000_0000, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 2);
`else
    // Divide requests are ignored entirely in this build
    for (int k = 0; k < 2; k++) begin
      op = (k == 0) ? 2'b10 : 2'b11;
      opa = 32'h0000_0009; opb = 32'h0000_0003; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("nodiv_busy", 64'(busy), 64'(0));
      done_cnt = 0;
      busy_cnt = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (done === 1'b1) done_cnt++;
        if (busy === 1'b1) busy_cnt++;
      end
      chk("nodiv_no_done", 64'(done_cnt), 64'(0));
      chk("nodiv_no_busy", 64'(busy_cnt), 64'(0));
      chk("nodiv_hi", 64'(hi_out), 64'(0));
      chk("nodiv_lo", 64'(lo_out), 64'h0000_0000_0000_001E);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
